// File: rtl/operand_read_port_if.sv
// operand_read_port_if: write-enable, read-handshake and display bus of the operand store
//  master (producer/consumer side): drives sel, wr_data, rd_req, rd_addr, rd_ready
//  slave  (operand_read_port):      drives rd_valid, rd_data, busy, sel_err, reg0_q, reg1_q
interface operand_read_port_if #(parameter int WIDTH = 4);
  logic [1:0]       sel;
  logic [WIDTH-1:0] wr_data;
  logic             rd_req;
  logic             rd_addr;
  logic             rd_ready;
  logic             rd_valid;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             sel_err;
  logic [WIDTH-1:0] reg0_q;
  logic [WIDTH-1:0] reg1_q;
  modport master(output sel, wr_data, rd_req, rd_addr, rd_ready,
                 input rd_valid, rd_data, busy, sel_err, reg0_q, reg1_q);
  modport slave(input sel, wr_data, rd_req, rd_addr, rd_ready,
                output rd_valid, rd_data, busy, sel_err, reg0_q, reg1_q);
endinterface

// File: rtl/operand_read_port.sv
// operand_read_port: two-entry operand store written by one-hot enables, read over valid/ready
//  clk  in  system clock, rising edge
//  rst  in  synchronous active-high reset
//  bus  slave modport: sel/wr_data write side, rd_req/rd_addr/rd_ready/rd_valid/rd_data
//       read handshake, busy, sticky sel_err, live reg0_q/reg1_q views
module operand_read_port #(parameter int WIDTH = 4) (
  input logic               clk,
  input logic               rst,
  operand_read_port_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_reg0, r_reg1, r_rd_data, w_fetch;
  logic             r_addr, r_rd_valid, r_sel_err, w_we0, w_we1;
  assign w_we0 = bus.sel == 2'b01;
  assign w_we1 = bus.sel == 2'b10;
  // a same-cycle legal write to the addressed register wins over the stored value
  assign w_fetch = r_addr ? (w_we1 ? bus.wr_data : r_reg1) : (w_we0 ? bus.wr_data : r_reg0);
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE)    ? (bus.rd_req ? FETCH : IDLE) :
             (r_state == FETCH)   ? PRESENT :
             (r_state == PRESENT) ? (bus.rd_ready ? IDLE : PRESENT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_reg0     <= '0;
      r_reg1     <= '0;
      r_addr     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_we0) r_reg0 <= bus.wr_data;
      if (w_we1) r_reg1 <= bus.wr_data;
      if (bus.sel == 2'b11) r_sel_err <= 1'b1;
      if (r_state == IDLE && bus.rd_req) r_addr <= bus.rd_addr;
      if (r_state == FETCH) begin
        r_rd_data  <= w_fetch;
        r_rd_valid <= 1'b1;
      end
      if (r_state == PRESENT && bus.rd_ready) r_rd_valid <= 1'b0;
    end
  end
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.busy     = r_state != IDLE;
  assign bus.sel_err  = r_sel_err;
  assign bus.reg0_q   = r_reg0;
  assign bus.reg1_q   = r_reg1;
endmodule
